// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter call sequencer.
// Holds the FSM states, the fault codes and the depth-counter width helper.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    RET_WAIT = 3'd2,
    HALTED   = 3'd3,
    FAULT    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    F_NONE     = 2'd0,
    F_OVF      = 2'd1,
    F_UNF      = 2'd2,
    F_CONFLICT = 2'd3
  } fault_t;

  // One extra bit so the counter can hold the full-stack value STACK_DEPTH.
  function automatic int depth_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/pc_call_sequencer.sv
// PC sequencer driving a return-address stack; owns the call depth and
// refuses any push/pop that would over- or under-run the reset-less stack.
module pc_call_sequencer
  import pc_seq_pkg::*;
#(
  parameter int D           = 12,
  parameter int STACK_DEPTH = 8,
  localparam int DW         = depth_width(STACK_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [D-1:0]  start_addr,
  input  logic          stall,
  input  logic          halt,
  input  logic          jump,
  input  logic          call,
  input  logic          ret,
  input  logic [D-1:0]  jump_target,
  input  logic [D-1:0]  ras_target_out,
  output logic [D-1:0]  pc,
  output logic          fetch_valid,
  output logic [D-1:0]  ras_addr,
  output logic [D-1:0]  ras_target_in,
  output logic          ras_call,
  output logic          ras_ret,
  output logic [DW-1:0] depth,
  output logic          done,
  output logic          fault,
  output logic [1:0]    fault_code
);

  localparam logic [DW-1:0] DEPTH_FULL = DW'(STACK_DEPTH);

  state_t        state_r, state_s;
  logic [D-1:0]  pc_r, pc_s;
  logic [DW-1:0] depth_r, depth_s;
  logic          done_r, done_s;
  logic          fault_r, fault_s;
  fault_t        code_r, code_s;
  logic          fetch_valid_s;
  logic          ras_call_s;
  logic          ras_ret_s;

  // Next-state, next-PC, depth bookkeeping and same-cycle stack strobes.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    depth_s       = depth_r;
    done_s        = done_r;
    fault_s       = fault_r;
    code_s        = code_r;
    fetch_valid_s = 1'b0;
    ras_call_s    = 1'b0;
    ras_ret_s     = 1'b0;

    case (state_r)
      IDLE, HALTED: begin
        if (start) begin
          pc_s    = start_addr;
          depth_s = '0;
          done_s  = 1'b0;
          state_s = RUN;
        end else begin
          state_s = state_r;
        end
      end

      RUN: begin
        if (stall) begin
          state_s = RUN;
        end else begin
          fetch_valid_s = 1'b1;
          if (call && ret) begin
            state_s = FAULT;
            fault_s = 1'b1;
            code_s  = F_CONFLICT;
          end else if (halt) begin
            state_s = HALTED;
            done_s  = 1'b1;
          end else if (ret) begin
            if (depth_r == '0) begin
              state_s = FAULT;
              fault_s = 1'b1;
              code_s  = F_UNF;
            end else begin
              ras_ret_s = 1'b1;
              state_s   = RET_WAIT;
            end
          end else if (call) begin
            if (depth_r == DEPTH_FULL) begin
              state_s = FAULT;
              fault_s = 1'b1;
              code_s  = F_OVF;
            end else begin
              ras_call_s = 1'b1;
              pc_s       = jump_target;
              depth_s    = depth_r + DW'(1);
            end
          end else if (jump) begin
            pc_s = jump_target;
          end else begin
            pc_s = pc_r + D'(1);
          end
        end
      end

      // Stack output is only valid now, so stall cannot defer this cycle.
      RET_WAIT: begin
        pc_s    = ras_target_out;
        depth_s = depth_r - DW'(1);
        state_s = RUN;
      end

      FAULT: begin
        state_s = FAULT;
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      pc_r    <= '0;
      depth_r <= '0;
      done_r  <= 1'b0;
      fault_r <= 1'b0;
      code_r  <= F_NONE;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      depth_r <= depth_s;
      done_r  <= done_s;
      fault_r <= fault_s;
      code_r  <= code_s;
    end
  end

  assign pc            = pc_r;
  assign depth         = depth_r;
  assign done          = done_r;
  assign fault         = fault_r;
  assign fault_code    = code_r;
  assign fetch_valid   = fetch_valid_s;
  assign ras_call      = ras_call_s;
  assign ras_ret       = ras_ret_s;
  assign ras_addr      = pc_r;
  assign ras_target_in = jump_target;

endmodule

// File: tb/tb_pc_call_sequencer.sv
// Scoreboard bench for pc_call_sequencer: stimulus queues expected fetches,
// a negedge monitor pops and compares whenever fetch_valid is high.
module tb_pc_call_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stall, halt, jump, call, ret;
  logic [11:0] start_addr, jump_target, ras_target_out;
  logic [11:0] pc, ras_addr, ras_target_in;
  logic        fetch_valid, ras_call, ras_ret, done, fault;
  logic [3:0]  depth;
  logic [1:0]  fault_code;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [11:0] pc;
    logic [3:0]  dp;
    logic        c;
    logic        r;
  } exp_t;

  exp_t q[$];

  localparam logic [5:0] N  = 6'b000000;
  localparam logic [5:0] ST = 6'b100000;
  localparam logic [5:0] SL = 6'b010000;
  localparam logic [5:0] HA = 6'b001000;
  localparam logic [5:0] JP = 6'b000100;
  localparam logic [5:0] CA = 6'b000010;
  localparam logic [5:0] RT = 6'b000001;

  pc_call_sequencer #(.D(12), .STACK_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .stall(stall), .halt(halt), .jump(jump), .call(call), .ret(ret),
    .jump_target(jump_target), .ras_target_out(ras_target_out),
    .pc(pc), .fetch_valid(fetch_valid), .ras_addr(ras_addr),
    .ras_target_in(ras_target_in), .ras_call(ras_call), .ras_ret(ras_ret),
    .depth(depth), .done(done), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1);
  end

  // Monitor: pops one expectation per valid fetch; strobes must be quiet otherwise.
  always @(negedge clk) begin
    if (!reset) begin
      if (fetch_valid) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL fetch_unexpected: pc=%h depth=%0d, required no fetch", pc, depth);
        end else begin
          exp_t e;
          e = q.pop_front();
          if ({pc, depth, ras_call, ras_ret} !== e) begin
            n_bad++;
            $display("FAIL fetch: got pc=%h depth=%0d call=%b ret=%b, required pc=%h depth=%0d call=%b ret=%b",
                     pc, depth, ras_call, ras_ret, e.pc, e.dp, e.c, e.r);
          end
        end
      end else begin
        n_cmp++;
        if ({ras_call, ras_ret} !== 2'b00) begin
          n_bad++;
          $display("FAIL idle_strobes: got call=%b ret=%b, required 0 0", ras_call, ras_ret);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [5:0] ctl, input logic [11:0] jt, input logic [11:0] rt,
                     input bit fv, input logic [11:0] epc, input logic [3:0] edp,
                     input bit ec, input bit er);
    @(posedge clk); #1;
    {start, stall, halt, jump, call, ret} = ctl;
    jump_target    = jt;
    ras_target_out = rt;
    if (fv) q.push_back({epc, edp, ec, er});
    @(negedge clk);
  endtask

  task automatic chk_reset_state();
    chk("rst_pc", 16'(pc), 16'h0000);
    chk("rst_depth", 16'(depth), 16'h0000);
    chk("rst_fault", 16'(fault), 16'h0000);
    chk("rst_code", 16'(fault_code), 16'h0000);
    chk("rst_done", 16'(done), 16'h0000);
    chk("rst_fv", 16'({fetch_valid, ras_call, ras_ret}), 16'h0000);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    {start, stall, halt, jump, call, ret} = N;
    @(negedge clk);
    chk_reset_state();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [11:0] epc;
    reset = 1'b1;
    {start, stall, halt, jump, call, ret} = N;
    start_addr = 12'h000; jump_target = 12'h000; ras_target_out = 12'h000;
    @(negedge clk);
    chk_reset_state();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);

    // Sequential wrap
    start_addr = 12'hFFE;
    cyc(ST, 12'h000, 12'h000, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0);
    cyc(N,  12'h000, 12'h000, 1'b1, 12'hFFE, 4'd0, 1'b0, 1'b0);
    cyc(N,  12'h000, 12'h000, 1'b1, 12'hFFF, 4'd0, 1'b0, 1'b0);
    cyc(N,  12'h000, 12'h000, 1'b1, 12'h000, 4'd0, 1'b0, 1'b0);
    cyc(JP, 12'h010, 12'h000, 1'b1, 12'h001, 4'd0, 1'b0, 1'b0);

    // Call/return round trip
    cyc(CA, 12'h200, 12'h000, 1'b1, 12'h010, 4'd0, 1'b1, 1'b0);
    chk("ras_addr", 16'(ras_addr), 16'h0010);
    chk("ras_target_in", 16'(ras_target_in), 16'h0200);
    cyc(N,  12'h000, 12'h000, 1'b1, 12'h200, 4'd1, 1'b0, 1'b0);
    cyc(RT, 12'h000, 12'h000, 1'b1, 12'h201, 4'd1, 1'b0, 1'b1);
    cyc(N,  12'h000, 12'h011, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0);
    cyc(N,  12'h000, 12'h000, 1'b1, 12'h011, 4'd0, 1'b0, 1'b0);

    // Stalled call is deferred to the first unstalled cycle
    cyc(SL | CA, 12'h300, 12'h000, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0);
    chk("stall_pc_hold", 16'(pc), 16'h0012);
    cyc(CA, 12'h300, 12'h000, 1'b1, 12'h012, 4'd0, 1'b1, 1'b0);
    cyc(RT, 12'h000, 12'h000, 1'b1, 12'h300, 4'd1, 1'b0, 1'b1);
    cyc(SL, 12'h000, 12'h013, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0);
    cyc(N,  12'h000, 12'h000, 1'b1, 12'h013, 4'd0, 1'b0, 1'b0);

    // Halt and restart
    cyc(HA, 12'h000, 12'h000, 1'b1, 12'h014, 4'd0, 1'b0, 1'b0);
    cyc(N,  12'h000, 12'h000, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0);
    chk("halted_done", 16'(done), 16'h0001);
    start_addr = 12'h100;
    cyc(ST, 12'h000, 12'h000, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0);

    // Nested overflow
    for (int i = 0; i < 8; i++) begin
      epc = (i == 0) ? 12'h100 : 12'(12'h400 + (i - 1) * 16);
      cyc(CA, 12'(12'h400 + i * 16), 12'h000, 1'b1, epc, 4'(i), 1'b1, 1'b0);
      if (i == 0) chk("restart_done_clr", 16'(done), 16'h0000);
    end
    cyc(CA, 12'h500, 12'h000, 1'b1, 12'h470, 4'd8, 1'b0, 1'b0);
    cyc(ST, 12'h000, 12'h000, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0);
    chk("ovf_fault", 16'(fault), 16'h0001);
    chk("ovf_code", 16'(fault_code), 16'h0001);
    chk("ovf_depth", 16'(depth), 16'h0008);
    chk("ovf_pc", 16'(pc), 16'h0470);
    cyc(N,  12'h000, 12'h000, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0);
    chk("ovf_sticky", 16'({fault, fault_code}), 16'h0005);
    do_reset();

    // Underflow
    start_addr = 12'h020;
    cyc(ST, 12'h000, 12'h000, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0);
    cyc(RT, 12'h000, 12'h000, 1'b1, 12'h020, 4'd0, 1'b0, 1'b0);
    cyc(N,  12'h000, 12'h000, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0);
    chk("unf_code", 16'({fault, fault_code}), 16'h0006);
    do_reset();

    // Call and ret together
    start_addr = 12'h030;
    cyc(ST, 12'h000, 12'h000, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0);
    cyc(CA | RT, 12'h777, 12'h000, 1'b1, 12'h030, 4'd0, 1'b0, 1'b0);
    cyc(N,  12'h000, 12'h000, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0);
    chk("conflict_code", 16'({fault, fault_code}), 16'h0007);
    do_reset();

    // Reset while waiting on the stack output
    start_addr = 12'h050;
    cyc(ST, 12'h000, 12'h000, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0);
    cyc(CA, 12'h060, 12'h000, 1'b1, 12'h050, 4'd0, 1'b1, 1'b0);
    cyc(RT, 12'h000, 12'h000, 1'b1, 12'h060, 4'd1, 1'b0, 1'b1);
    do_reset();
    start_addr = 12'h040;
    cyc(ST, 12'h000, 12'h000, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0);
    cyc(N,  12'h000, 12'h000, 1'b1, 12'h040, 4'd0, 1'b0, 1'b0);

    @(posedge clk); #1;
    {start, stall, halt, jump, call, ret} = N;
    chk("queue_drain", 16'(q.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
